memory: RTL and testbench

- Synchronous true dual-port RAM with two independent read/write ports, A and B.
- Both ports share one clock and one storage array of 2^ADDR words, each DATA bits wide.
- Used as a general on-chip scratch/data store. Either port can write to or read from any location in any cycle.

---
 rtl/memory.sv | 37 +++
 tb/tb_memory.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/memory.sv
// True dual-port synchronous RAM: two independent read/write ports sharing one
// clock and one array, registered read data, port A wins same-address writes.
module memory #(
    parameter int ADDR = 4,
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_wr,
    input  logic [ADDR-1:0] a_addr,
    input  logic [DATA-1:0] a_din,
    output logic [DATA-1:0] a_dout,
    input  logic            b_wr,
    input  logic [ADDR-1:0] b_addr,
    input  logic [DATA-1:0] b_din,
    output logic [DATA-1:0] b_dout
);

    localparam int unsigned DEPTH = 1 << ADDR;

    logic [DATA-1:0] mem [DEPTH];

    // Reads sample the array before this edge's writes land, so a reader on the
    // other port sees old data; A's write is scheduled last so it wins collisions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_dout <= '0;
            b_dout <= '0;
        end else begin
            if (b_wr) mem[b_addr] <= b_din;
            if (a_wr) mem[a_addr] <= a_din;
            if (!a_wr) a_dout <= mem[a_addr];
            if (!b_wr) b_dout <= mem[b_addr];
        end
    end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed vector table followed by random
// traffic compared against a behavioural array model.
module tb_memory;

    localparam int ADDR  = 4;
    localparam int DATA  = 8;
    localparam int DEPTH = 1 << ADDR;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            a_wr, b_wr;
    logic [ADDR-1:0] a_addr, b_addr;
    logic [DATA-1:0] a_din, b_din;
    logic [DATA-1:0] a_dout, b_dout;

    memory #(.ADDR(ADDR), .DATA(DATA)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_wr   (a_wr),
        .a_addr (a_addr),
        .a_din  (a_din),
        .a_dout (a_dout),
        .b_wr   (b_wr),
        .b_addr (b_addr),
        .b_din  (b_din),
        .b_dout (b_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst_n;
        logic            a_wr;
        logic [ADDR-1:0] a_addr;
        logic [DATA-1:0] a_din;
        logic            b_wr;
        logic [ADDR-1:0] b_addr;
        logic [DATA-1:0] b_din;
        logic            chk_a;
        logic [DATA-1:0] exp_a;
        logic            chk_b;
        logic [DATA-1:0] exp_b;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model: plain word array plus "has been written" flags.
    logic [DATA-1:0] ref_mem   [DEPTH];
    bit              ref_known [DEPTH];
    logic [DATA-1:0] exp_a, exp_b;
    bit              exp_a_known = 0, exp_b_known = 0;

    task automatic check(input string name, input logic [DATA-1:0] got,
                         input logic [DATA-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic aw, input int aa, input int ad,
                                input logic bw, input int ba, input int bd,
                                input logic ca, input int ea, input logic cb, input int eb);
        vec_t v;
        v.rst_n = r;  v.a_wr = aw; v.a_addr = ADDR'(aa); v.a_din = DATA'(ad);
        v.b_wr = bw;  v.b_addr = ADDR'(ba); v.b_din = DATA'(bd);
        v.chk_a = ca; v.exp_a = DATA'(ea); v.chk_b = cb; v.exp_b = DATA'(eb);
        return v;
    endfunction

    task automatic step(input vec_t v);
        rst_n = v.rst_n;
        a_wr = v.a_wr; a_addr = v.a_addr; a_din = v.a_din;
        b_wr = v.b_wr; b_addr = v.b_addr; b_din = v.b_din;
        @(posedge clk);
        if (!v.rst_n) begin
            exp_a = '0; exp_a_known = 1;
            exp_b = '0; exp_b_known = 1;
        end else begin
            if (!v.a_wr) begin exp_a = ref_mem[v.a_addr]; exp_a_known = ref_known[v.a_addr]; end
            if (!v.b_wr) begin exp_b = ref_mem[v.b_addr]; exp_b_known = ref_known[v.b_addr]; end
            if (v.b_wr) begin ref_mem[v.b_addr] = v.b_din; ref_known[v.b_addr] = 1; end
            if (v.a_wr) begin ref_mem[v.a_addr] = v.a_din; ref_known[v.a_addr] = 1; end
        end
        #1;
    endtask

    vec_t tbl[21];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 0;

        //            rst aw aa  ad    bw ba  bd    ca ea    cb eb
        for (int i = 0; i < 5; i++)
            tbl[i] = mk(0, 0, 0, 0,    0, 0, 0,    1, 0,    1, 0);
        tbl[5]  = mk(1, 1, 3, 234,  0, 0, 0,    1, 0,    0, 0);
        tbl[6]  = mk(1, 1, 4, 222,  0, 0, 0,    1, 0,    0, 0);
        tbl[7]  = mk(1, 0, 3, 0,    0, 0, 0,    1, 234,  0, 0);
        tbl[8]  = mk(1, 1, 10, 'h99, 0, 0, 0,   1, 234,  0, 0);
        tbl[9]  = mk(1, 1, 3, 234,  1, 15, 255, 1, 234,  0, 0);
        tbl[10] = mk(1, 0, 15, 0,   0, 3, 0,    1, 255,  1, 234);
        tbl[11] = mk(1, 1, 0, 1,    0, 3, 0,    1, 255,  1, 234);
        tbl[12] = mk(1, 0, 0, 0,    0, 0, 0,    1, 1,    1, 1);
        tbl[13] = mk(1, 1, 7, 'h11, 1, 7, 'h22, 1, 1,    1, 1);
        tbl[14] = mk(1, 0, 7, 0,    0, 7, 0,    1, 'h11, 1, 'h11);
        tbl[15] = mk(1, 1, 5, 'hAA, 0, 4, 0,    1, 'h11, 1, 222);
        tbl[16] = mk(1, 1, 5, 'h55, 0, 5, 0,    1, 'h11, 1, 'hAA);
        tbl[17] = mk(1, 0, 5, 0,    0, 5, 0,    1, 'h55, 1, 'h55);
        tbl[18] = mk(1, 1, 9, 'h3C, 0, 10, 0,   1, 'h55, 1, 'h99);
        tbl[19] = mk(0, 1, 9, 'hFF, 1, 9, 'hEE, 1, 0,    1, 0);
        tbl[20] = mk(1, 0, 9, 0,    0, 9, 0,    1, 'h3C, 1, 'h3C);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i]);
            if (tbl[i].chk_a) check($sformatf("vec%0d_a_dout", i), a_dout, tbl[i].exp_a);
            if (tbl[i].chk_b) check($sformatf("vec%0d_b_dout", i), b_dout, tbl[i].exp_b);
        end

        // Fill every word so random reads always have a defined expectation.
        for (int i = 0; i < DEPTH / 2; i++) begin
            v = mk(1, 1, 2 * i, $urandom_range(0, 255), 1, 2 * i + 1, $urandom_range(0, 255), 0, 0, 0, 0);
            step(v);
            check("fill_a_hold", a_dout, exp_a);
            check("fill_b_hold", b_dout, exp_b);
        end

        for (int i = 0; i < 500; i++) begin
            v = mk(($urandom_range(0, 24) != 0),
                   1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
                   1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
                   0, 0, 0, 0);
            // Bias toward shared addresses to exercise collisions and read-during-write.
            if ($urandom_range(0, 3) == 0) v.b_addr = v.a_addr;
            step(v);
            if (exp_a_known) check("rand_a_dout", a_dout, exp_a);
            if (exp_b_known) check("rand_b_dout", b_dout, exp_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
